// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers, WIDTH+1 cycles per operation.
// Define MULDIV_DIV_EN to compile in the restoring divider; otherwise every start is a multiply.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands and signs latched on acceptance
// RUN   | one shift-add / restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO write, done pulse follows
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic             div,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             lohi,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [2*WIDTH-1:0] acc;
    logic               neg_lo;
    logic               op_div;
    logic               is_div;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MULDIV_DIV_EN
    logic               neg_hi;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0]   quo, rem;

    assign is_div = div;
`else
    logic unused_div;

    assign is_div     = 1'b0;
    assign op_div     = 1'b0;
    assign unused_div = div;
`endif

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps cleanly.
    assign sa    = sgn & srca[WIDTH-1];
    assign sb    = sgn & srcb[WIDTH-1];
    assign mag_a = sa ? -srca : srca;
    assign mag_b = sb ? -srcb : srcb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != S_IDLE);
        result = lohi ? hi : lo;
    end

    // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
        mul_nxt = {add_sum, acc[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    // Restoring step: acc holds {remainder, remaining dividend/quotient bits}.
    always_comb begin
        div_sh    = {acc, 1'b0};
        div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opa};
        div_nxt   = div_trial[WIDTH] ? div_sh[2*WIDTH-1:0]
                                     : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
    end
`endif

    always_comb begin
        prod   = neg_lo ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        quo = acc[WIDTH-1:0];
        rem = acc[2*WIDTH-1:WIDTH];
        if (op_div) begin
            if (div_zero) begin
                fix_lo = {WIDTH{1'b1}};
                fix_hi = a_raw;
            end else begin
                fix_lo = neg_lo ? -quo : quo;
                fix_hi = neg_hi ? -rem : rem;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            opa    <= '0;
            acc    <= '0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_div   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
`endif
        end else begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        opa    <= is_div ? mag_b : mag_a;
                        acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                        neg_lo <= sa ^ sb;
`ifdef MULDIV_DIV_EN
                        op_div   <= is_div;
                        neg_hi   <= sa;
                        div_zero <= (srcb == '0);
                        a_raw    <= srca;
`endif
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
`ifdef MULDIV_DIV_EN
                    acc <= op_div ? div_nxt : mul_nxt;
`else
                    acc <= mul_nxt;
`endif
                end
                S_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It is the parametrised successor to the single-cycle mult path driven by the controller's `multstart`/`multsgn`/`lohi` outputs. Operations take WIDTH+1 cycles and use a `busy`/`done` handshake so the hazard unit can stall `mfhi`/`mflo` and back-to-back `mult`. It sits in the execute stage beside the ALU; `result` feeds the `aluormult` mux.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `sgn`  in  1  1 = signed (two's complement) operands, 0 = unsigned.
- `div`  in  1  1 = divide, 0 = multiply. Ignored unless `MULDIV_DIV_EN` is defined.
- `srca`  in  WIDTH  multiplicand or dividend.
- `srcb`  in  WIDTH  multiplier or divisor.
- `lohi`  in  1  read select: 1 = HI, 0 = LO.
- `result`  out  WIDTH  `lohi ? hi : lo`, combinational from the registers.
- `hi`, `lo`  out  WIDTH each  architectural HI and LO registers.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse; HI and LO were just written.

## Operation
States:
- IDLE: `start`=1 latches the operands. When `sgn`=1, it also latches each operand's magnitude and the result sign(s). Next state is RUN and the bit counter loads 0.
- RUN: processes one bit per cycle for exactly WIDTH cycles, then goes to FIX.
- FIX: applies sign correction, writes HI and LO, and returns to IDLE.

Datapath:
- Multiply: radix-2 shift-add on magnitudes into a 2·WIDTH accumulator. If signed and the operand signs differ, the 2·WIDTH product is two's-complement negated. HI gets the upper WIDTH bits, LO the lower.
- Magnitudes are unsigned WIDTH-bit values. For example, |−2^(WIDTH−1)| = 2^(WIDTH−1) with no overflow.
- Divide (macro only): restoring division on magnitudes. LO gets the quotient, HI the remainder. Signed quotient sign is `sa^sb`; signed remainder takes the sign of the dividend. −2^(W−1) / −1 wraps to a quotient of 0x8000_0000 (W=32) with remainder 0.
- Divide by zero: LO = all ones, HI = `srca`. It runs the same WIDTH+1-cycle latency; there is no trap.

Boundary conditions:
- `start` while `busy`=1: ignored. The operation in flight is unaffected.
- `start` in the `done` cycle: accepted, since the FSM is already in IDLE.
- HI and LO hold their previous values for the whole of an operation. `result` remains readable but stale; the pipeline must stall reads on `busy`.
- Operand inputs may change after the start edge. Only the latched copies are used.

## Timing
- Start accepted at edge 0.
- `busy`=1 after edges 0 through WIDTH (RUN for WIDTH cycles, FIX for 1 cycle).
- HI and LO are written at edge WIDTH+1. After that edge, `busy`=0 and `done`=1 for exactly one cycle.
- Total latency: WIDTH+1 cycles, regardless of operand values.
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, therefore `result`=0.
- Reset asserted mid-operation aborts immediately, with all of the reset values above. There is no partial write to HI or LO.

## Configuration
- `MULDIV_DIV_EN` defined: divide datapath compiled in; `div` selects the operation.
- `MULDIV_DIV_EN` undefined: divide logic is absent and `div` is ignored. Every start is a multiply, with identical timing.

## Test plan
- Unsigned mult, WIDTH=32, `srca`=`srcb`=0xFFFFFFFF, `sgn`=0 → at edge 33: HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- Signed mult −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Signed 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- Second `start` 10 cycles into an operation → ignored; only the first result is written and `done` pulses once. A new `start` in the `done` cycle is accepted and `busy` rises next edge.
- Reset asserted at cycle 15 of a mult → `busy`=0, HI=LO=0 immediately. A following mult 7×6 gives LO=42, HI=0 after 33 cycles.
- `lohi` toggled while idle after 7×6 → `result` alternates 42 / 0 combinationally. During a later op, `result` stays 42 until the write edge.
- With `MULDIV_DIV_EN`: signed −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Unsigned 100 / 0 → LO=0xFFFFFFFF, HI=100. Without the macro: `div`=1 with 6, 7 → LO=42.
